// File: rtl/frame_bank_scheduler_if.sv
// Controller-facing side of the frame bank scheduler:
// per-port load strobes and bank address windows.
interface frame_bank_scheduler_if;
  logic        wr_load;
  logic        rd_load;
  logic [28:0] app_addr_wr_min;
  logic [28:0] app_addr_wr_max;
  logic [28:0] app_addr_rd_min;
  logic [28:0] app_addr_rd_max;

  modport master (
    output wr_load,
    output rd_load,
    output app_addr_wr_min,
    output app_addr_wr_max,
    output app_addr_rd_min,
    output app_addr_rd_max
  );

  modport slave (
    input wr_load,
    input rd_load,
    input app_addr_wr_min,
    input app_addr_wr_max,
    input app_addr_rd_min,
    input app_addr_rd_max
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler between the frame writer and
// the display reader of the DDR3 frame store.
module frame_bank_scheduler #(
  parameter int FRAME_WORDS = 262144,
  parameter int BANK_STRIDE = 524288,
  parameter bit WR_VS_POL   = 1'b1,
  parameter bit RD_VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_vsync,
  input  logic        rd_vsync,
  input  logic        freeze,
  frame_bank_scheduler_if.master ctrl,
  output logic [1:0]  wr_bank,
  output logic [1:0]  rd_bank,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  repeat_cnt
);

  if ((BANK_STRIDE < FRAME_WORDS) ||
      (longint'(BANK_STRIDE) * 3 > (longint'(1) << 29))) begin : g_bad
    $error("frame_bank_scheduler: bad BANK_STRIDE");
  end

  localparam logic [28:0] STRIDE1 = 29'(BANK_STRIDE);
  localparam logic [28:0] STRIDE2 = 29'(2 * BANK_STRIDE);
  localparam logic [28:0] FW      = 29'(FRAME_WORDS);

  function automatic logic [28:0] base(input logic [1:0] idx);
    case (idx)
      2'd0:    base = 29'd0;
      2'd1:    base = STRIDE1;
      default: base = STRIDE2;
    endcase
  endfunction

  logic [2:0] wr_s;
  logic [2:0] rd_s;
  logic       wev;
  logic       rev;

  logic [1:0] w_idx;
  logic [1:0] r_idx;
  logic [1:0] latest_idx;
  logic       latest_valid;
  logic       latest_shown;
  logic       wr_active;

  logic [1:0] w_n;
  logic [1:0] r_n;
  logic [1:0] lat_n;
  logic       val_n;
  logic       shn_n;
  logic       drop_inc;
  logic       rep_inc;
  logic       free0;
  logic       free1;

  // Synchronizer flops reset to the inactive level so release is quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_s <= {3{~WR_VS_POL}};
      rd_s <= {3{~RD_VS_POL}};
    end else begin
      wr_s <= {wr_s[1:0], wr_vsync};
      rd_s <= {rd_s[1:0], rd_vsync};
    end
  end

  assign wev = (wr_s[1] == WR_VS_POL) && (wr_s[2] != WR_VS_POL);
  assign rev = (rd_s[1] == RD_VS_POL) && (rd_s[2] != RD_VS_POL);

  always_comb begin
    lat_n    = latest_idx;
    val_n    = latest_valid;
    shn_n    = latest_shown;
    drop_inc = 1'b0;
    if (wev && wr_active) begin
      lat_n    = w_idx;
      val_n    = 1'b1;
      shn_n    = 1'b0;
      drop_inc = latest_valid && !latest_shown;
    end

    r_n     = r_idx;
    rep_inc = 1'b0;
    if (rev) begin
      if (val_n && !freeze && (lat_n != r_idx)) begin
        r_n   = lat_n;
        shn_n = 1'b1;
      end else begin
        rep_inc = 1'b1;
        if (lat_n == r_idx) shn_n = 1'b1;
      end
    end

    free0 = (r_n != 2'd0) && !(val_n && (lat_n == 2'd0));
    free1 = (r_n != 2'd1) && !(val_n && (lat_n == 2'd1));
    w_n   = w_idx;
    if (wev) begin
      priority case (1'b1)
        free0:   w_n = 2'd0;
        free1:   w_n = 2'd1;
        default: w_n = 2'd2;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_idx                <= 2'd1;
      r_idx                <= 2'd0;
      latest_idx           <= 2'd0;
      latest_valid         <= 1'b0;
      latest_shown         <= 1'b0;
      wr_active            <= 1'b0;
      drop_cnt             <= 8'd0;
      repeat_cnt           <= 8'd0;
      ctrl.wr_load         <= 1'b0;
      ctrl.rd_load         <= 1'b0;
      ctrl.app_addr_wr_min <= STRIDE1;
      ctrl.app_addr_wr_max <= STRIDE1 + FW;
      ctrl.app_addr_rd_min <= 29'd0;
      ctrl.app_addr_rd_max <= FW;
    end else begin
      w_idx        <= w_n;
      r_idx        <= r_n;
      latest_idx   <= lat_n;
      latest_valid <= val_n;
      latest_shown <= shn_n;
      ctrl.wr_load <= wev;
      ctrl.rd_load <= rev;
      if (wev) begin
        wr_active            <= 1'b1;
        ctrl.app_addr_wr_min <= base(w_n);
        ctrl.app_addr_wr_max <= base(w_n) + FW;
      end
      if (rev) begin
        ctrl.app_addr_rd_min <= base(r_n);
        ctrl.app_addr_rd_max <= base(r_n) + FW;
      end
      if (drop_inc && (drop_cnt != 8'hff))
        drop_cnt <= drop_cnt + 8'd1;
      if (rep_inc && (repeat_cnt != 8'hff))
        repeat_cnt <= repeat_cnt + 8'd1;
    end
  end

  assign wr_bank = w_idx;
  assign rd_bank = r_idx;

  a_banks_differ : assert property (
    @(posedge clk) disable iff (!reset_n) w_idx != r_idx
  );

endmodule
